ccp_fill_data_monitor: RTL and testbench
========================================

# ccp_fill_data_monitor

Synthesizable protocol monitor and ID scoreboard for the CCP cache fill-data channel, placed in parallel with the controller-to-cache fill-data path. Tracks per-burst beat progress with run-time variable burst length, maintains the busy/outstanding fill-ID table, and reports six classes of protocol violation as sticky registered error flags. Produces first/last-beat qualifiers for downstream datapath and coverage logic.

## Interface
- TABLE_ENTRIES, 64, fill-ID table depth
- ID_W, $clog2(TABLE_ENTRIES), fill-ID width
- ADDRESS_W, 32, fill address width
- N_WAYS, 8, cache ways; WAY_W = $clog2(N_WAYS)
- BEAT_W, 3, beat-number width; max burst = 2^BEAT_W beats

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fill_data_valid  in  1  beat valid
- fill_data_ready  in  1  cache accepts beat
- fill_data_id  in  ID_W  fill ID
- fill_data_addr  in  ADDRESS_W  line address
- fill_data_way  in  WAY_W  target way
- fill_data_beat  in  BEAT_W  beat number
- fill_data_len  in  BEAT_W  beats-1; sampled on first beat only
- fill_done  in  1  cache retires a fill
- fill_done_id  in  ID_W  retired ID
- first_beat  out  1  valid && no burst in progress (combinational)
- last_beat  out  1  valid && beat index == burst length (combinational)
- busy_vec  out  TABLE_ENTRIES  registered busy IDs
- outstanding_cnt  out  ID_W+1  registered popcount of busy_vec
- err_vec  out  6  sticky error flags
- err_any  out  1  OR of err_vec
- err_id  out  ID_W  fill_data_id (or fill_done_id for bit 5) of first error

## Operation
- Burst FSM: IDLE, BURST. IDLE→BURST on accepted first beat with len≠0; stays IDLE if len==0 (single-beat fill, first_beat and last_beat both high). BURST→IDLE on accepted beat with index==stored len.
- Accepted first beat captures id, addr, way, len, beat; index counter cleared to 0, increments per accepted beat.
- Accepted first beat sets busy_vec[id]; fill_done clears busy_vec[fill_done_id]. Same-cycle clear and set of same ID: set wins.
- err_vec bits (flag set when condition seen):
  - 0 VALID_DROP: valid high and not ready last cycle, valid low now.
  - 1 STALL_PARAM: valid high and not ready last cycle, any of id/addr/way/beat/len changed.
  - 2 BURST_PARAM: in BURST, valid beat with id/addr/way ≠ captured.
  - 3 BEAT_SEQ: in BURST, beat ≠ expected next (see Configuration); or first-beat rule violated.
  - 4 ID_REUSE: accepted first beat whose ID is busy and not cleared by fill_done same cycle.
  - 5 DONE_UNBUSY: fill_done with busy_vec[fill_done_id]==0 (current-cycle set does not count).
- err_id captured only when err_any transitions 0→1; multiple simultaneous errors: lowest bit selects ID source.
- Monitor never back-pressures; state updates only on valid&&ready.

## Timing
- Reset: FSM IDLE, counters 0, busy_vec 0, outstanding_cnt 0, err_vec 0, err_any 0, err_id 0.
- Reset mid-burst: all state cleared next edge; following beat treated as first beat.
- err_vec/err_any: one cycle after offending edge; sticky until reset.
- busy_vec/outstanding_cnt: reflect accept/done one cycle later.
- first_beat/last_beat: zero latency, gated by fill_data_valid.
- Beat arithmetic modulo 2^BEAT_W.

## Configuration
- CCP_FILL_CWF_EN defined: critical-word-first; first beat may be any number; len+1 must be power of two (else BEAT_SEQ on first beat); expected next = (prev+1) & len.
- Not defined: first beat must be 0 (else BEAT_SEQ); expected next = prev+1; any len legal.

## Test plan
- len=3, id=5, beats 0,1,2,3 back-to-back, ready=1 → first_beat cycle 0, last_beat cycle 3, busy_vec[5]=1, outstanding_cnt=1, err_vec=0; fill_done id=5 → busy_vec=0 next cycle.
- Stall: valid=1, ready=0, addr changes 0x1000→0x1040 → err_vec[1]=1 next cycle, err_id=id, err_any sticky.
- id=7 busy, new first beat id=7 → err_vec[4]; repeat with fill_done id=7 same cycle → no error, busy_vec[7] stays 1.
- fill_done id=9 with nothing busy → err_vec[5], err_id=9.
- CWF_EN, len=3, beats 2,3,0,1 → no error; without macro → err_vec[3] on first beat.
- Reset asserted after beat 1 of len=7 burst → all outputs 0; next beat id=3 beat 0 accepted as first beat, no error.

Source files
------------

// File: rtl/ccp_fill_data_monitor.sv
// ccp_fill_data_monitor
//
// Passive protocol monitor and fill-ID scoreboard for the CCP cache fill-data
// channel. It sits in parallel with the controller-to-cache fill-data path and
// never back-pressures it. The monitor:
//   - follows each burst beat by beat, with the burst length sampled at run
//     time from the first beat,
//   - keeps the busy/outstanding fill-ID table,
//   - raises six sticky protocol-error flags,
//   - produces first/last-beat qualifiers for downstream logic.
//
// Optional feature: define CCP_FILL_CWF_EN for critical-word-first bursts.
//   - Defined: the first beat may carry any beat number, len+1 must be a
//     power of two, and the next beat is expected at (prev+1) & len.
//   - Undefined: the first beat must be beat 0 and beats count up by one.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   fill_data_valid    beat valid
//   fill_data_ready    cache accepts beat
//   fill_data_id       fill ID
//   fill_data_addr     line address
//   fill_data_way      target way
//   fill_data_beat     beat number
//   fill_data_len      beats-1, used from the first beat only
//   fill_done          cache retires a fill
//   fill_done_id       retired ID
//   first_beat         valid beat with no burst in progress (combinational)
//   last_beat          valid beat whose index equals burst length (combinational)
//   busy_vec           registered busy-ID table
//   outstanding_cnt    registered popcount of busy_vec
//   err_vec            sticky error flags:
//                        0 VALID_DROP, 1 STALL_PARAM, 2 BURST_PARAM,
//                        3 BEAT_SEQ, 4 ID_REUSE, 5 DONE_UNBUSY
//   err_any            sticky OR of err_vec
//   err_id             ID associated with the first error seen
module ccp_fill_data_monitor #(
  parameter int TABLE_ENTRIES = 64,
  parameter int ID_W          = $clog2(TABLE_ENTRIES),
  parameter int ADDRESS_W     = 32,
  parameter int N_WAYS        = 8,
  parameter int WAY_W         = $clog2(N_WAYS),
  parameter int BEAT_W        = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fill_data_valid,
  input  logic                     fill_data_ready,
  input  logic [ID_W-1:0]          fill_data_id,
  input  logic [ADDRESS_W-1:0]     fill_data_addr,
  input  logic [WAY_W-1:0]         fill_data_way,
  input  logic [BEAT_W-1:0]        fill_data_beat,
  input  logic [BEAT_W-1:0]        fill_data_len,
  input  logic                     fill_done,
  input  logic [ID_W-1:0]          fill_done_id,
  output logic                     first_beat,
  output logic                     last_beat,
  output logic [TABLE_ENTRIES-1:0] busy_vec,
  output logic [ID_W:0]            outstanding_cnt,
  output logic [5:0]               err_vec,
  output logic                     err_any,
  output logic [ID_W-1:0]          err_id
);

  localparam logic [BEAT_W-1:0]        BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0]        BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [TABLE_ENTRIES-1:0] TAB_ZERO  = {TABLE_ENTRIES{1'b0}};
  localparam logic [TABLE_ENTRIES-1:0] TAB_ONE   = {{(TABLE_ENTRIES-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Number of set bits in a busy table.
  function automatic logic [ID_W:0] popcount(input logic [TABLE_ENTRIES-1:0] vec);
    logic [ID_W:0] cnt;
    cnt = {(ID_W+1){1'b0}};
    for (int i = 0; i < TABLE_ENTRIES; i++) begin
      cnt = cnt + {{ID_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Burst state captured from the first beat.
  state_t                 state_r;
  logic [ID_W-1:0]        id_r;
  logic [ADDRESS_W-1:0]   addr_r;
  logic [WAY_W-1:0]       way_r;
  logic [BEAT_W-1:0]      len_r;
  logic [BEAT_W-1:0]      beat_r;   // beat number of the last accepted beat
  logic [BEAT_W-1:0]      cnt_r;    // index of the beat currently on the bus

  // Copy of last cycle's beat, used to detect illegal changes during a stall.
  logic                   hold_r;
  logic [ID_W-1:0]        hold_id_r;
  logic [ADDRESS_W-1:0]   hold_addr_r;
  logic [WAY_W-1:0]       hold_way_r;
  logic [BEAT_W-1:0]      hold_beat_r;
  logic [BEAT_W-1:0]      hold_len_r;

  logic                     in_burst_s;
  logic                     accept_s;
  logic                     first_acc_s;
  logic [BEAT_W-1:0]        len_inc_s;
  logic [BEAT_W-1:0]        exp_beat_s;
  logic                     first_bad_s;
  logic [TABLE_ENTRIES-1:0] done_mask_s;
  logic [TABLE_ENTRIES-1:0] set_mask_s;
  logic [TABLE_ENTRIES-1:0] busy_next_s;
  logic [5:0]               err_new_s;
  logic [ID_W-1:0]          err_id_next_s;

  // Beat qualifiers, next busy table and this cycle's protocol violations.
  always_comb begin
    in_burst_s  = (state_r == BURST);
    accept_s    = fill_data_valid & fill_data_ready;
    first_acc_s = accept_s & ~in_burst_s;
    len_inc_s   = fill_data_len + BEAT_ONE;
`ifdef CCP_FILL_CWF_EN
    // Wrap within the burst; a burst of len+1 beats must be a power of two.
    exp_beat_s  = (beat_r + BEAT_ONE) & len_r;
    first_bad_s = ((fill_data_len & len_inc_s) != BEAT_ZERO);
`else
    exp_beat_s  = beat_r + BEAT_ONE;
    first_bad_s = (fill_data_beat != BEAT_ZERO);
`endif

    first_beat = fill_data_valid & ~in_burst_s;
    if (in_burst_s) begin
      last_beat = fill_data_valid & (cnt_r == len_r);
    end else begin
      last_beat = fill_data_valid & (fill_data_len == BEAT_ZERO);
    end

    // Set wins over a same-cycle clear of the same ID.
    done_mask_s = fill_done ? (TAB_ONE << fill_done_id) : TAB_ZERO;
    set_mask_s  = first_acc_s ? (TAB_ONE << fill_data_id) : TAB_ZERO;
    busy_next_s = (busy_vec & ~done_mask_s) | set_mask_s;

    err_new_s    = 6'b000000;
    err_new_s[0] = hold_r & ~fill_data_valid;
    err_new_s[1] = hold_r & fill_data_valid &
                   ((fill_data_id   != hold_id_r)   |
                    (fill_data_addr != hold_addr_r) |
                    (fill_data_way  != hold_way_r)  |
                    (fill_data_beat != hold_beat_r) |
                    (fill_data_len  != hold_len_r));
    err_new_s[2] = in_burst_s & fill_data_valid &
                   ((fill_data_id   != id_r)   |
                    (fill_data_addr != addr_r) |
                    (fill_data_way  != way_r));
    if (in_burst_s) begin
      err_new_s[3] = fill_data_valid & (fill_data_beat != exp_beat_s);
    end else begin
      err_new_s[3] = fill_data_valid & first_bad_s;
    end
    // Busy status is the registered table: a same-cycle set does not count.
    err_new_s[4] = first_acc_s & busy_vec[fill_data_id] &
                   ~(fill_done & (fill_done_id == fill_data_id));
    err_new_s[5] = fill_done & ~busy_vec[fill_done_id];

    // Lowest flagged bit picks the ID source; only DONE_UNBUSY uses fill_done_id.
    if (err_new_s[4:0] != 5'b00000) begin
      err_id_next_s = fill_data_id;
    end else begin
      err_id_next_s = fill_done_id;
    end
  end

  // Burst FSM: capture on the first accepted beat, count beats until the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      id_r    <= {ID_W{1'b0}};
      addr_r  <= {ADDRESS_W{1'b0}};
      way_r   <= {WAY_W{1'b0}};
      len_r   <= BEAT_ZERO;
      beat_r  <= BEAT_ZERO;
      cnt_r   <= BEAT_ZERO;
    end else if (accept_s) begin
      case (state_r)
        IDLE: begin
          id_r   <= fill_data_id;
          addr_r <= fill_data_addr;
          way_r  <= fill_data_way;
          len_r  <= fill_data_len;
          beat_r <= fill_data_beat;
          // First beat is index 0, so the next beat on the bus is index 1.
          cnt_r  <= BEAT_ONE;
          if (fill_data_len != BEAT_ZERO) begin
            state_r <= BURST;
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          beat_r <= fill_data_beat;
          cnt_r  <= cnt_r + BEAT_ONE;
          if (cnt_r == len_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Remember a stalled beat so the next cycle can check that it held steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r      <= 1'b0;
      hold_id_r   <= {ID_W{1'b0}};
      hold_addr_r <= {ADDRESS_W{1'b0}};
      hold_way_r  <= {WAY_W{1'b0}};
      hold_beat_r <= BEAT_ZERO;
      hold_len_r  <= BEAT_ZERO;
    end else begin
      hold_r      <= fill_data_valid & ~fill_data_ready;
      hold_id_r   <= fill_data_id;
      hold_addr_r <= fill_data_addr;
      hold_way_r  <= fill_data_way;
      hold_beat_r <= fill_data_beat;
      hold_len_r  <= fill_data_len;
    end
  end

  // Busy-ID table and its population count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec        <= TAB_ZERO;
      outstanding_cnt <= {(ID_W+1){1'b0}};
    end else begin
      busy_vec        <= busy_next_s;
      outstanding_cnt <= popcount(busy_next_s);
    end
  end

  // Sticky error flags; the ID is latched only for the very first error.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_vec <= 6'b000000;
      err_any <= 1'b0;
      err_id  <= {ID_W{1'b0}};
    end else begin
      err_vec <= err_vec | err_new_s;
      err_any <= err_any | (|err_new_s);
      if (!err_any && (|err_new_s)) begin
        err_id <= err_id_next_s;
      end else begin
        err_id <= err_id;
      end
    end
  end

endmodule

// File: tb/tb_ccp_fill_data_monitor.sv
module tb_ccp_fill_data_monitor;

`ifdef CCP_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fill_data_valid, fill_data_ready;
  logic [5:0]  fill_data_id;
  logic [31:0] fill_data_addr;
  logic [2:0]  fill_data_way, fill_data_beat, fill_data_len;
  logic        fill_done;
  logic [5:0]  fill_done_id;
  logic        first_beat, last_beat;
  logic [63:0] busy_vec;
  logic [6:0]  outstanding_cnt;
  logic [5:0]  err_vec;
  logic        err_any;
  logic [5:0]  err_id;

  always #5 clk = ~clk;

  ccp_fill_data_monitor dut (
    .clk(clk), .reset(reset),
    .fill_data_valid(fill_data_valid), .fill_data_ready(fill_data_ready),
    .fill_data_id(fill_data_id), .fill_data_addr(fill_data_addr),
    .fill_data_way(fill_data_way), .fill_data_beat(fill_data_beat),
    .fill_data_len(fill_data_len), .fill_done(fill_done),
    .fill_done_id(fill_done_id), .first_beat(first_beat), .last_beat(last_beat),
    .busy_vec(busy_vec), .outstanding_cnt(outstanding_cnt), .err_vec(err_vec),
    .err_any(err_any), .err_id(err_id)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_active;      // a multi-beat burst is open
  int          m_id, m_way, m_len, m_start, m_k;  // m_k = index of the next beat
  logic [31:0] m_addr;
  bit          m_busy[64];
  bit [5:0]    m_err;
  int          m_eid;
  bit          m_hold;
  int          h_id, h_way, h_beat, h_len;
  logic [31:0] h_addr;
  bit          model_on = 1'b0;

  task automatic model_reset();
    m_active = 0; m_id = 0; m_way = 0; m_len = 0; m_start = 0; m_k = 0; m_addr = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_err = 0; m_eid = 0; m_hold = 0;
    h_id = 0; h_way = 0; h_beat = 0; h_len = 0; h_addr = 0;
  endtask

  function automatic bit m_first();
    return fill_data_valid && !m_active;
  endfunction

  function automatic bit m_last();
    if (!fill_data_valid) return 0;
    if (m_active) return (m_k == m_len);
    return (int'(fill_data_len) == 0);
  endfunction

  task automatic model_update();
    bit [5:0] e;
    int exp_b, len_i;
    bit acc;
    if (reset) begin
      model_reset();
      return;
    end
    e = 0;
    acc = fill_data_valid && fill_data_ready;
    len_i = int'(fill_data_len);
    if (m_hold && !fill_data_valid) e[0] = 1;
    if (m_hold && fill_data_valid &&
        (int'(fill_data_id) != h_id || fill_data_addr != h_addr || int'(fill_data_way) != h_way ||
         int'(fill_data_beat) != h_beat || len_i != h_len)) e[1] = 1;
    if (m_active && fill_data_valid &&
        (int'(fill_data_id) != m_id || fill_data_addr != m_addr || int'(fill_data_way) != m_way)) e[2] = 1;
    if (fill_data_valid) begin
      if (m_active) begin
        exp_b = CWF ? ((m_start + m_k) & m_len) : ((m_start + m_k) % 8);
        if (int'(fill_data_beat) != exp_b) e[3] = 1;
      end else if (CWF) begin
        if (!((len_i + 1) inside {1, 2, 4, 8})) e[3] = 1;
      end else if (fill_data_beat != 3'd0) begin
        e[3] = 1;
      end
    end
    if (acc && !m_active && m_busy[fill_data_id] && !(fill_done && fill_done_id == fill_data_id)) e[4] = 1;
    if (fill_done && !m_busy[fill_done_id]) e[5] = 1;
    if (m_err == 0 && e != 0) m_eid = (e[4:0] != 0) ? int'(fill_data_id) : int'(fill_done_id);
    m_err |= e;
    if (fill_done) m_busy[fill_done_id] = 0;
    if (acc && !m_active) m_busy[fill_data_id] = 1;
    if (acc) begin
      if (!m_active) begin
        if (len_i != 0) begin
          m_active = 1; m_id = int'(fill_data_id); m_addr = fill_data_addr;
          m_way = int'(fill_data_way); m_len = len_i; m_start = int'(fill_data_beat); m_k = 1;
        end
      end else if (m_k == m_len) begin
        m_active = 0;
      end else begin
        m_k++;
      end
    end
    m_hold = fill_data_valid && !fill_data_ready;
    h_id = int'(fill_data_id); h_addr = fill_data_addr; h_way = int'(fill_data_way);
    h_beat = int'(fill_data_beat); h_len = len_i;
  endtask

  task automatic check_model();
    logic [63:0] b;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      b[i] = m_busy[i];
      cnt += int'(m_busy[i]);
    end
    chk("model_first_beat", first_beat, m_first());
    chk("model_last_beat", last_beat, m_last());
    chk("model_busy_vec", busy_vec, b);
    chk("model_outstanding", outstanding_cnt, cnt);
    chk("model_err_vec", err_vec, m_err);
    chk("model_err_any", err_any, m_err != 0);
    chk("model_err_id", err_id, m_eid);
  endtask

  // Called with inputs already applied, between clock edges.
  task automatic step();
    #1;
    if (model_on) check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit v, input bit r, input int id, input logic [31:0] addr,
                       input int way, input int beat, input int len, input bit done, input int did);
    reset = rst; fill_data_valid = v; fill_data_ready = r;
    fill_data_id = 6'(id); fill_data_addr = addr; fill_data_way = 3'(way);
    fill_data_beat = 3'(beat); fill_data_len = 3'(len);
    fill_done = done; fill_done_id = 6'(did);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, v, r;
    logic [5:0]  id;
    logic [31:0] addr;
    logic [2:0]  beat, len;
    bit          done;
    logic [5:0]  did;
    bit          xf, xl;
    logic [5:0]  xerr;
    logic [6:0]  xcnt;
    logic [63:0] xbusy;
    logic [5:0]  xeid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit v, input bit r, input int id, input logic [31:0] addr,
                              input int beat, input int len, input bit done, input int did,
                              input bit xf, input bit xl, input int xerr, input int xcnt,
                              input int bid, input int xeid);
    vec_t t;
    t.rst = rst; t.v = v; t.r = r; t.id = 6'(id); t.addr = addr;
    t.beat = 3'(beat); t.len = 3'(len); t.done = done; t.did = 6'(did);
    t.xf = xf; t.xl = xl; t.xerr = 6'(xerr); t.xcnt = 7'(xcnt);
    t.xbusy = (bid < 0) ? 64'd0 : (64'd1 << bid);
    t.xeid = 6'(xeid);
    return t;
  endfunction

  // random-driver state
  bit          d_active, d_hold, rv, rr, rdone, acc;
  int          d_start, d_k, cur_id, cur_way, cur_beat, cur_len, rdid;
  logic [31:0] cur_addr;

  initial begin
    // Burst len=3 id=5, then retire it.
    tbl.push_back(mk(0,1,1,5,32'h1000,0,3,0,0, 1,0, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,5,32'h1000,1,3,0,0, 0,0, 0,1, 5,0));
    tbl.push_back(mk(0,1,1,5,32'h1000,2,3,0,0, 0,0, 0,1, 5,0));
    tbl.push_back(mk(0,1,1,5,32'h1000,3,3,0,0, 0,1, 0,1, 5,0));
    tbl.push_back(mk(0,0,0,5,32'h1000,0,0,1,5, 0,0, 0,1, 5,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 0,0,-1,0));
    // Address changes while stalled.
    tbl.push_back(mk(0,1,0,2,32'h1000,0,0,0,0, 1,1, 0,0,-1,0));
    tbl.push_back(mk(0,1,0,2,32'h1040,0,0,0,0, 1,1, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,2,32'h1040,0,0,0,0, 1,1, 2,0,-1,2));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 2,1, 2,2));
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 2,1, 2,2));
    // ID reuse, then reuse covered by a same-cycle retire.
    tbl.push_back(mk(0,1,1,7,32'h2000,0,0,0,0, 1,1, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,7,32'h2000,0,0,0,0, 1,1, 0,1, 7,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0,16,1, 7,7));
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0,16,1, 7,7));
    tbl.push_back(mk(0,1,1,7,32'h2000,0,0,0,0, 1,1, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,7,32'h2000,0,0,1,7, 1,1, 0,1, 7,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 0,1, 7,0));
    // Retire of an ID that is not busy.
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 0,1, 7,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,1,9, 0,0, 0,0,-1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0,32,0,-1,9));
    // Reset in the middle of a len=7 burst.
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0,32,0,-1,9));
    tbl.push_back(mk(0,1,1,4,32'h3000,0,7,0,0, 1,0, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,4,32'h3000,1,7,0,0, 0,0, 0,1, 4,0));
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 0,1, 4,0));
    tbl.push_back(mk(0,1,1,3,32'h3000,0,0,0,0, 1,1, 0,0,-1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 0,1, 3,0));
    // Valid dropped during a stall.
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 0,1, 3,0));
    tbl.push_back(mk(0,1,0,6,32'h4000,0,1,0,0, 1,0, 0,0,-1,0));
    tbl.push_back(mk(0,0,0,6,32'h4000,0,1,0,0, 0,0, 0,0,-1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 1,0,-1,6));
    // Address changes mid-burst.
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 1,0,-1,6));
    tbl.push_back(mk(0,1,1,1,32'h5000,0,1,0,0, 1,0, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,1,32'h5040,1,1,0,0, 0,1, 0,1, 1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 4,1, 1,1));
    // Skipped beat number mid-burst.
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 4,1, 1,1));
    tbl.push_back(mk(0,1,1,1,32'h6000,0,3,0,0, 1,0, 0,0,-1,0));
    tbl.push_back(mk(0,1,1,1,32'h6000,2,3,0,0, 0,0, 0,1, 1,0));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 8,1, 1,1));
    tbl.push_back(mk(1,0,0,0,32'h0,   0,0,0,0, 0,0, 8,1, 1,1));
    tbl.push_back(mk(0,0,0,0,32'h0,   0,0,0,0, 0,0, 0,0,-1,0));

    // Power-on reset.
    model_reset();
    @(negedge clk);
    drive(1,0,0,0,32'h0,0,0,0,0,0);
    step();
    model_on = 1'b1;
    step();
    drive(0,0,0,0,32'h0,0,0,0,0,0);
    #1;
    chk("reset_first_beat", first_beat, 0);
    chk("reset_last_beat", last_beat, 0);
    chk("reset_busy_vec", busy_vec, 0);
    chk("reset_outstanding", outstanding_cnt, 0);
    chk("reset_err_vec", err_vec, 0);
    chk("reset_err_any", err_any, 0);
    chk("reset_err_id", err_id, 0);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].r, int'(tbl[i].id), tbl[i].addr, 0,
            int'(tbl[i].beat), int'(tbl[i].len), tbl[i].done, int'(tbl[i].did));
      #1;
      chk($sformatf("tbl%0d_first_beat", i), first_beat, tbl[i].xf);
      chk($sformatf("tbl%0d_last_beat", i), last_beat, tbl[i].xl);
      chk($sformatf("tbl%0d_err_vec", i), err_vec, tbl[i].xerr);
      chk($sformatf("tbl%0d_err_any", i), err_any, |tbl[i].xerr);
      chk($sformatf("tbl%0d_outstanding", i), outstanding_cnt, tbl[i].xcnt);
      chk($sformatf("tbl%0d_busy_vec", i), busy_vec, tbl[i].xbusy);
      chk($sformatf("tbl%0d_err_id", i), err_id, tbl[i].xeid);
      step();
    end

    // Critical-word-first order 2,3,0,1 for len=3.
    drive(1,0,0,0,32'h0,0,0,0,0,0); step();
    drive(0,1,1,10,32'h7000,2,2,3,0,0); #1;
    chk("cwf_first_beat", first_beat, 1);
    chk("cwf_first_not_last", last_beat, 0);
    step();
    drive(0,1,1,10,32'h7000,2,3,3,0,0); step();
    drive(0,1,1,10,32'h7000,2,0,3,0,0); step();
    drive(0,1,1,10,32'h7000,2,1,3,0,0); #1;
    chk("cwf_last_beat", last_beat, 1);
    step();
    drive(0,0,0,0,32'h0,0,0,0,0,0); #1;
    chk("cwf_order_err_vec", err_vec, CWF ? 0 : 8);
    chk("cwf_order_err_id", err_id, CWF ? 0 : 10);
    chk("cwf_order_outstanding", outstanding_cnt, 1);
    step();

    // len=2 is not a power-of-two burst in critical-word-first mode.
    drive(1,0,0,0,32'h0,0,0,0,0,0); step();
    drive(0,1,1,11,32'h8000,0,0,2,0,0); step();
    drive(0,1,1,11,32'h8000,0,1,2,0,0); step();
    drive(0,1,1,11,32'h8000,0,2,2,0,0); #1;
    chk("len2_last_beat", last_beat, 1);
    step();
    drive(0,0,0,0,32'h0,0,0,0,0,0); #1;
    chk("len2_err_vec", err_vec, CWF ? 8 : 0);
    chk("len2_err_id", err_id, CWF ? 11 : 0);
    step();

    // Randomized traffic, mostly legal, with occasional injected violations.
    for (int ep = 0; ep < 30; ep++) begin
      drive(1,0,0,0,32'h0,0,0,0,0,0);
      step();
      d_active = 0; d_hold = 0; d_k = 0; d_start = 0;
      cur_id = 0; cur_addr = 0; cur_way = 0; cur_beat = 0; cur_len = 0; rv = 0;
      for (int c = 0; c < 60; c++) begin
        if (!d_hold) begin
          rv = ($urandom_range(0, 9) < 7);
          if (!d_active) begin
            cur_id = $urandom_range(0, 15);
            cur_addr = $urandom;
            cur_way = $urandom_range(0, 7);
            if (CWF) begin
              case ($urandom_range(0, 3))
                0: cur_len = 0;
                1: cur_len = 1;
                2: cur_len = 3;
                default: cur_len = 7;
              endcase
              cur_beat = $urandom_range(0, 7);
            end else begin
              cur_len = $urandom_range(0, 7);
              cur_beat = 0;
            end
            d_start = cur_beat;
          end else begin
            cur_beat = CWF ? ((d_start + d_k) & cur_len) : ((d_start + d_k) % 8);
          end
        end
        rr = ($urandom_range(0, 9) < 7);
        rdone = ($urandom_range(0, 4) == 0);
        rdid = $urandom_range(0, 15);
        if (rdone && !m_busy[rdid] && $urandom_range(0, 3) != 0) rdone = 0;
        if ($urandom_range(0, 59) == 0) begin
          case ($urandom_range(0, 3))
            0: rv = !rv;
            1: cur_addr = cur_addr ^ 32'h40;
            2: cur_beat = (cur_beat + 1) % 8;
            default: cur_id = cur_id ^ 1;
          endcase
        end
        drive(0, rv, rr, cur_id, cur_addr, cur_way, cur_beat, cur_len, rdone, rdid);
        acc = rv && rr;
        step();
        d_hold = rv && !rr;
        if (acc) begin
          if (!d_active) begin
            if (cur_len != 0) begin
              d_active = 1;
              d_k = 1;
            end
          end else if (d_k == cur_len) begin
            d_active = 0;
          end else begin
            d_k++;
          end
        end
      end
    end

    drive(0,0,0,0,32'h0,0,0,0,0,0);
    step();
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
